// File: rtl/data_mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : data_mem_arbiter_if
// Brief  : Requester ports A/B and data memory bus for data_mem_arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface data_mem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [15:0] a_addr;
    logic [15:0] a_wdata;
    logic        a_ack;
    logic [15:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [15:0] b_addr;
    logic [15:0] b_wdata;
    logic        b_ack;
    logic [15:0] b_rdata;

    logic        mem_rd;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        busy;

    // Requesters and the memory, seen from outside the arbiter.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_rd, mem_write, mem_addr, wr_data, busy,
        output rd_data
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_rd, mem_write, mem_addr, wr_data, busy,
        input  rd_data
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : data_mem_arbiter
// Brief  : Two-port (A/B) arbiter onto a single-port data memory, fixed
//          3-cycle IDLE/ACCESS/RESP sequence. DATA_MEM_ARB_ROUND_ROBIN_EN
//          selects round-robin tie-break; otherwise port A has fixed priority.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        id_q, id_d;         // winner: 0 = A, 1 = B
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] a_rdata_q, a_rdata_d;
    logic [15:0] b_rdata_q, b_rdata_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic        grant_b;
    logic        any_req;
    logic        in_access;

    assign any_req   = bus.a_req | bus.b_req;
    assign in_access = (state_q == ACCESS);

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    logic last_b_q, last_b_d;

    // On a tie, B wins only if A was granted last.
    assign grant_b = bus.b_req & (~bus.a_req | ~last_b_q);

    always_comb begin
        last_b_d = last_b_q;
        if ((state_q == IDLE) && any_req) begin
            last_b_d = grant_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    assign grant_b = bus.b_req & ~bus.a_req;
`endif

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    id_d    = grant_b;
                    we_d    = grant_b ? bus.b_we    : bus.a_we;
                    addr_d  = grant_b ? bus.b_addr  : bus.a_addr;
                    wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
                end
            end
            ACCESS: begin
                state_d = RESP;
                a_ack_d = ~id_q;
                b_ack_d = id_q;
                if (!we_q) begin
                    if (id_q) begin
                        b_rdata_d = bus.rd_data;
                    end else begin
                        a_rdata_d = bus.rd_data;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            a_rdata_q <= 16'h0000;
            b_rdata_q <= 16'h0000;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
        end
    end

    // Strobes are gated by rst_n so a reset landing on ACCESS cannot write.
    assign bus.mem_rd    = rst_n & in_access & ~we_q;
    assign bus.mem_write = rst_n & in_access & we_q;
    assign bus.mem_addr  = in_access ? addr_q : 16'h0000;
    assign bus.wr_data   = (in_access & we_q) ? wdata_q : 16'h0000;
    assign bus.busy      = (state_q != IDLE);
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_data_mem_arbiter
// Brief  : Directed self-checking bench for data_mem_arbiter with a small
//          behavioural data memory behind the arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_cnt   = 0;

    logic [15:0] mem [0:255];

    data_mem_arbiter_if bus();

    data_mem_arbiter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.rd_data = mem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr[7:0]] <= bus.wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    a_rd_wr_excl: assert property (@(posedge clk) !(bus.mem_rd && bus.mem_write))
        else $error("FAIL rd_wr_excl: mem_rd and mem_write both high");

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise a request, wait (bounded) for its ack, check latency and read data.
    task automatic run_access(input bit port, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] exp_rdata,
                              input string tag);
        int n;
        bit acked;
        @(posedge clk); #1;
        if (!port) begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end else begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end
        n = 0;
        acked = 1'b0;
        while (!acked && n < 8) begin
            @(posedge clk); #1;
            n++;
            acked = port ? bus.b_ack : bus.a_ack;
        end
        check_eq({tag, "_lat"}, n, 2);
        if (!we) check_eq({tag, "_rdata"}, port ? bus.b_rdata : bus.a_rdata, exp_rdata);
        if (!port) bus.a_req = 1'b0;
        else       bus.b_req = 1'b0;
    endtask

    initial begin
        int wr0;
        int ng;
        bit gr [4];
        int gc [4];
        bit exp_gr [4];
        logic [15:0] exp_b_hold;

        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 16'h0; bus.a_wdata = 16'h0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 16'h0; bus.b_wdata = 16'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy",    bus.busy,      0);
        check_eq("rst_a_ack",   bus.a_ack,     0);
        check_eq("rst_b_ack",   bus.b_ack,     0);
        check_eq("rst_a_rdata", bus.a_rdata,   0);
        check_eq("rst_b_rdata", bus.b_rdata,   0);
        check_eq("rst_mem_wr",  bus.mem_write, 0);
        check_eq("rst_mem_rd",  bus.mem_rd,    0);
        check_eq("rst_mem_adr", bus.mem_addr,  0);
        rst_n = 1'b1;

        // A write BEEF to 0010 with cycle-accurate checks
        @(posedge clk); #1;
        wr0 = wr_cnt;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'h0010; bus.a_wdata = 16'hBEEF;
        @(posedge clk); #1;
        check_eq("wr_acc_mem_wr",  bus.mem_write, 1);
        check_eq("wr_acc_mem_rd",  bus.mem_rd,    0);
        check_eq("wr_acc_addr",    bus.mem_addr,  16'h0010);
        check_eq("wr_acc_wdata",   bus.wr_data,   16'hBEEF);
        check_eq("wr_acc_busy",    bus.busy,      1);
        check_eq("wr_acc_ack",     bus.a_ack,     0);
        @(posedge clk); #1;
        check_eq("wr_resp_a_ack",  bus.a_ack,     1);
        check_eq("wr_resp_b_ack",  bus.b_ack,     0);
        check_eq("wr_resp_mem_wr", bus.mem_write, 0);
        check_eq("wr_resp_addr",   bus.mem_addr,  0);
        check_eq("wr_resp_wdata",  bus.wr_data,   0);
        check_eq("wr_a_rdata",     bus.a_rdata,   0);
        bus.a_req = 1'b0;
        @(posedge clk); #1;
        check_eq("wr_idle_busy",   bus.busy,      0);
        check_eq("wr_idle_ack",    bus.a_ack,     0);
        check_eq("wr_pulse_count", wr_cnt - wr0,  1);
        run_access(1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, "rd_beef");

        // Preload via the arbiter
        run_access(1'b1, 1'b1, 16'hFFFF, 16'h5A5A, 16'h0, "pre_ffff");
        run_access(1'b0, 1'b1, 16'h0001, 16'h1111, 16'h0, "pre_0001");
        run_access(1'b1, 1'b1, 16'h0002, 16'h2222, 16'h0, "pre_0002");
        run_access(1'b0, 1'b1, 16'h0030, 16'h7777, 16'h0, "pre_0030");
        check_eq("a_rdata_hold_wr", bus.a_rdata, 16'hBEEF);

        // Top address read
        run_access(1'b0, 1'b0, 16'hFFFF, 16'h0, 16'h5A5A, "rd_ffff");

        // Reset during ACCESS of a write
        @(posedge clk); #1;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'h0030; bus.a_wdata = 16'hDEAD;
        @(posedge clk); #1;
        check_eq("rstacc_pre_wr", bus.mem_write, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rstacc_gate_wr", bus.mem_write, 0);
        @(posedge clk); #1;
        check_eq("rstacc_busy",  bus.busy,  0);
        check_eq("rstacc_a_ack", bus.a_ack, 0);
        bus.a_req = 1'b0;
        rst_n = 1'b1;

        // Both ports continuously read; pointer freshly reset
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        exp_gr = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_b_hold = 16'h2222;
`else
        exp_gr = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_b_hold = 16'h0000;
`endif
        @(posedge clk); #1;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0001;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'h0002;
        ng = 0;
        for (int cyc = 1; cyc <= 16 && ng < 4; cyc++) begin
            @(posedge clk); #1;
            if (bus.a_ack && bus.b_ack) check_eq("tie_both_ack", 1, 0);
            if (bus.a_ack || bus.b_ack) begin
                gr[ng] = bus.b_ack;
                gc[ng] = cyc;
                if (bus.b_ack) check_eq("tie_b_rdata", bus.b_rdata, 16'h2222);
                else           check_eq("tie_a_rdata", bus.a_rdata, 16'h1111);
                ng++;
            end
        end
        check_eq("tie_grants", ng, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                check_eq($sformatf("tie_grant%0d", i), gr[i], exp_gr[i]);
                check_eq($sformatf("tie_cycle%0d", i), gc[i], 2 + 3 * i);
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;

        // B write while A/B inputs wiggle during ACCESS
        @(posedge clk); #1;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0020; bus.b_wdata = 16'h1234;
        bus.a_addr = 16'h0000;
        @(posedge clk); #1;
        check_eq("hold_addr0", bus.mem_addr, 16'h0020);
        bus.a_addr = 16'hFFFF; bus.b_addr = 16'h0055; bus.b_wdata = 16'h9999;
        #1;
        check_eq("hold_addr1",  bus.mem_addr, 16'h0020);
        check_eq("hold_wdata1", bus.wr_data,  16'h1234);
        @(negedge clk);
        bus.a_addr = 16'h00AA;
        #1;
        check_eq("hold_addr2", bus.mem_addr, 16'h0020);
        @(posedge clk); #1;
        check_eq("hold_b_ack",   bus.b_ack,   1);
        check_eq("hold_b_rdata", bus.b_rdata, exp_b_hold);
        bus.b_req = 1'b0;

        run_access(1'b0, 1'b0, 16'h0020, 16'h0, 16'h1234, "rd_0020");
        run_access(1'b0, 1'b0, 16'h0030, 16'h0, 16'h7777, "rd_0030");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
